hazard_scoreboard: RTL

Parametrised hazard scoreboard for the pipelined CPU, replacing the fixed EX/MEM- and MEM/WB-compare forwarding and hazard logic. It tracks every in-flight register write across a configurable number of post-decode stages, issues load-use stalls for a configurable load latency, and inserts bubbles on flush. It also produces registered forwarding selects for the instruction entering EX. It sits beside the decode stage and drives PC write, IF/ID write and control zeroing.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_match.sv | 32 +++
 rtl/hazard_scoreboard.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard and its operand match units.
package hazard_pkg;

    // Scoreboard entries store rd zero-extended to this width; REG_ADDR_W must not exceed it.
    localparam int unsigned SB_RD_W = 8;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               is_load;
    } sb_entry_t;

    // fwd_sel: 0 = regfile value, k in 1..DEPTH-1 = result held after stage k-1,
    // DEPTH = retired-write holding register kept one cycle past WB.
    localparam int unsigned FWD_REGFILE = 0;

    function automatic int unsigned fwd_sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer search for one source operand across all scoreboard stages.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned SEL_W = 2
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic                  use_op,
    input  logic [SB_RD_W-1:0]    idx,
    output logic                  hit,
    output logic [SEL_W-1:0]      stage,
    output logic                  is_load
);

    always_comb begin
        hit     = 1'b0;
        stage   = '0;
        is_load = 1'b0;
        if (use_op && (idx != '0)) begin
            // Walk oldest to youngest so the lowest matching stage wins.
            for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
                if (entries[s].valid && (entries[s].rd == idx)) begin
                    hit     = 1'b1;
                    stage   = SEL_W'(s);
                    is_load = entries[s].is_load;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight write scoreboard: load-use stall, flush bubbles and registered forwarding selects.
// Optional performance counters (stall_cycles, flush_count) are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_LAT   = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             issue_valid,
    input  logic                             issue_reg_write,
    input  logic                             issue_is_load,
    input  logic [REG_ADDR_W-1:0]            issue_rd,
    input  logic                             use_rs1,
    input  logic                             use_rs2,
    input  logic [REG_ADDR_W-1:0]            rs1,
    input  logic [REG_ADDR_W-1:0]            rs2,
    input  logic                             flush,
    output logic                             stall,
    output logic                             pc_write,
    output logic                             if_id_write,
    output logic                             bubble,
    output logic [fwd_sel_width(DEPTH)-1:0]  fwd_sel_rs1,
    output logic [fwd_sel_width(DEPTH)-1:0]  fwd_sel_rs2
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]                 stall_cycles,
    output logic [CNT_W-1:0]                 flush_count
`endif
);

    localparam int unsigned FwdW = fwd_sel_width(DEPTH);

    sb_entry_t [DEPTH-1:0] entry_q, entry_d;
    logic [FwdW-1:0]       fwd_rs1_q, fwd_rs1_d, fwd_rs2_q, fwd_rs2_d;
    logic                  hit1, hit2, ld1, ld2, haz1, haz2;
    logic [FwdW-1:0]       stage1, stage2;

    hazard_match #(
        .DEPTH (DEPTH),
        .SEL_W (FwdW)
    ) u_match_rs1 (
        .entries (entry_q),
        .use_op  (use_rs1),
        .idx     (SB_RD_W'(rs1)),
        .hit     (hit1),
        .stage   (stage1),
        .is_load (ld1)
    );

    hazard_match #(
        .DEPTH (DEPTH),
        .SEL_W (FwdW)
    ) u_match_rs2 (
        .entries (entry_q),
        .use_op  (use_rs2),
        .idx     (SB_RD_W'(rs2)),
        .hit     (hit2),
        .stage   (stage2),
        .is_load (ld2)
    );

    // The producer advances one stage before the consumer reaches EX.
    always_comb begin
        haz1 = hit1 && ld1 && ((32'(stage1) + 32'd1) < LOAD_LAT);
        haz2 = hit2 && ld2 && ((32'(stage2) + 32'd1) < LOAD_LAT);
    end

    assign stall       = (haz1 | haz2) & ~flush & ~reset;
    assign bubble      = stall | flush;
    assign pc_write    = ~stall;
    assign if_id_write = ~stall;

    always_comb begin
        entry_d = '0;
        for (int s = 1; s < int'(DEPTH); s++) begin
            entry_d[s] = entry_q[s-1];
        end
        if (issue_valid && !bubble && issue_reg_write && (issue_rd != '0)) begin
            entry_d[0].valid   = 1'b1;
            entry_d[0].rd      = SB_RD_W'(issue_rd);
            entry_d[0].is_load = issue_is_load;
        end

        fwd_rs1_d = FwdW'(FWD_REGFILE);
        fwd_rs2_d = FwdW'(FWD_REGFILE);
        if (issue_valid && !bubble) begin
            if (hit1) fwd_rs1_d = stage1 + FwdW'(1);
            if (hit2) fwd_rs2_d = stage2 + FwdW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q   <= '0;
            fwd_rs1_q <= '0;
            fwd_rs2_q <= '0;
        end else begin
            entry_q   <= entry_d;
            fwd_rs1_q <= fwd_rs1_d;
            fwd_rs2_q <= fwd_rs2_d;
        end
    end

    assign fwd_sel_rs1 = fwd_rs1_q;
    assign fwd_sel_rs2 = fwd_rs2_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Free-running counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
            flush_cnt_q <= flush_cnt_q + CNT_W'(flush);
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule
